// File: rtl/adder_arbiter_8bits.sv
// Two-requester arbiter sharing one registered 8-bit adder (IDLE -> EXEC -> DONE, 3 cycles/op).
// Define ADDER_ARB_STATS_EN to add saturating Arb_ops / Arb_ovf completion counters.
module adder_arbiter_8bits #(
    parameter int ARB_MODE = 0
) (
    input  logic       Arb_clk,
    input  logic       Arb_rst,
    input  logic       Arb_req0,
    input  logic       Arb_req1,
    input  logic [7:0] Arb_in1_0,
    input  logic [7:0] Arb_in2_0,
    input  logic [7:0] Arb_in1_1,
    input  logic [7:0] Arb_in2_1,
    input  logic       Arb_cin_0,
    input  logic       Arb_cin_1,
    output logic [1:0] Arb_grant,
    output logic       Arb_done0,
    output logic       Arb_done1,
    output logic [7:0] Arb_sum,
    output logic       Arb_cout,
    output logic       Arb_busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [7:0] Arb_ops,
    output logic [7:0] Arb_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [7:0] sum_q, sum_d;
    logic       cout_q, cout_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic       opc_q, opc_d;
    logic       win1;

    // last_q holds the index of the requester served most recently
    always_comb begin
        if (ARB_MODE == 1) begin
            win1 = !Arb_req0;
        end else if (Arb_req0 && Arb_req1) begin
            win1 = !last_q;
        end else begin
            win1 = !Arb_req0;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        case (state_q)
            IDLE: begin
                if (Arb_req0 || Arb_req1) begin
                    state_d = EXEC;
                    grant_d = win1 ? 2'b10 : 2'b01;
                    opa_d   = win1 ? Arb_in1_1 : Arb_in1_0;
                    opb_d   = win1 ? Arb_in2_1 : Arb_in2_0;
                    opc_d   = win1 ? Arb_cin_1 : Arb_cin_0;
                end
            end
            EXEC: begin
                {cout_d, sum_d} = {1'b0, opa_q} + {1'b0, opb_q} + {8'd0, opc_q};
                state_d         = DONE;
            end
            DONE: begin
                // done is registered here, so it is visible in the cycle after leaving DONE
                done0_d = grant_q[0];
                done1_d = grant_q[1];
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Arb_clk or posedge Arb_rst) begin
        if (Arb_rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            sum_q   <= 8'd0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_ff @(posedge Arb_clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        opc_q <= opc_d;
    end

    assign Arb_grant = grant_q;
    assign Arb_done0 = done0_q;
    assign Arb_done1 = done1_q;
    assign Arb_sum   = sum_q;
    assign Arb_cout  = cout_q;
    assign Arb_busy  = (state_q != IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [7:0] ops_q, ops_d;
    logic [7:0] ovf_q, ovf_d;

    always_comb begin
        ops_d = ops_q;
        ovf_d = ovf_q;
        if (done0_d || done1_d) begin
            if (ops_q != 8'hFF) ops_d = ops_q + 8'd1;
            if (cout_q && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge Arb_clk or posedge Arb_rst) begin
        if (Arb_rst) begin
            ops_q <= 8'd0;
            ovf_q <= 8'd0;
        end else begin
            ops_q <= ops_d;
            ovf_q <= ovf_d;
        end
    end

    assign Arb_ops = ops_q;
    assign Arb_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter_8bits.sv
// Bench for adder_arbiter_8bits: round-robin and fixed-priority instances share one stimulus stream.
module tb_adder_arbiter_8bits;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b1, req1 = 1'b1;
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic       c0 = 1'b0, c1 = 1'b0;

    logic [1:0] g_rr, g_fp;
    logic       d0_rr, d1_rr, d0_fp, d1_fp;
    logic [7:0] s_rr, s_fp;
    logic       co_rr, co_fp, bz_rr, bz_fp;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0] ops_rr, ovf_rr, ops_fp, ovf_fp;
`endif

    always #5 clk = ~clk;

    adder_arbiter_8bits #(.ARB_MODE(0)) u_rr (
        .Arb_clk(clk), .Arb_rst(rst), .Arb_req0(req0), .Arb_req1(req1),
        .Arb_in1_0(a0), .Arb_in2_0(b0), .Arb_in1_1(a1), .Arb_in2_1(b1),
        .Arb_cin_0(c0), .Arb_cin_1(c1),
        .Arb_grant(g_rr), .Arb_done0(d0_rr), .Arb_done1(d1_rr),
        .Arb_sum(s_rr), .Arb_cout(co_rr), .Arb_busy(bz_rr)
`ifdef ADDER_ARB_STATS_EN
        , .Arb_ops(ops_rr), .Arb_ovf(ovf_rr)
`endif
    );

    adder_arbiter_8bits #(.ARB_MODE(1)) u_fp (
        .Arb_clk(clk), .Arb_rst(rst), .Arb_req0(req0), .Arb_req1(req1),
        .Arb_in1_0(a0), .Arb_in2_0(b0), .Arb_in1_1(a1), .Arb_in2_1(b1),
        .Arb_cin_0(c0), .Arb_cin_1(c1),
        .Arb_grant(g_fp), .Arb_done0(d0_fp), .Arb_done1(d1_fp),
        .Arb_sum(s_fp), .Arb_cout(co_fp), .Arb_busy(bz_fp)
`ifdef ADDER_ARB_STATS_EN
        , .Arb_ops(ops_fp), .Arb_ovf(ovf_fp)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who was served last, last completed {cout,sum}, completion counters
    int last_rr = 1, last_fp = 1;
    int m_res_rr = 0, m_res_fp = 0;
    int m_ops_rr = 0, m_ovf_rr = 0, m_ops_fp = 0, m_ovf_fp = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic [1:0] g, input logic b, input logic d1,
                                         input logic d0, input int r);
        logic [8:0] rs;
        rs = r[8:0];
        return {2'b00, g, b, d1, d0, rs};
    endfunction

    function automatic int pick(input int mode, input bit r0, input bit r1, input int last);
        if (mode == 1) return r0 ? 0 : 1;
        if (r0 && r1) return 1 - last;
        return r0 ? 0 : 1;
    endfunction

    function automatic logic [1:0] gbits(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk_both(input string tag, input logic [15:0] e_rr, input logic [15:0] e_fp);
        chk({tag, "_rr"}, pack(g_rr, bz_rr, d1_rr, d0_rr, int'({co_rr, s_rr})), e_rr);
        chk({tag, "_fp"}, pack(g_fp, bz_fp, d1_fp, d0_fp, int'({co_fp, s_fp})), e_fp);
    endtask

    task automatic chk_stats(input string tag);
`ifdef ADDER_ARB_STATS_EN
        chk({tag, "_ops_rr"}, {8'd0, ops_rr}, 16'(m_ops_rr));
        chk({tag, "_ovf_rr"}, {8'd0, ovf_rr}, 16'(m_ovf_rr));
        chk({tag, "_ops_fp"}, {8'd0, ops_fp}, 16'(m_ops_fp));
        chk({tag, "_ovf_fp"}, {8'd0, ovf_fp}, 16'(m_ovf_fp));
`else
        n_cmp = n_cmp + 0;
`endif
    endtask

    task automatic model_reset();
        last_rr = 1;  last_fp = 1;
        m_res_rr = 0; m_res_fp = 0;
        m_ops_rr = 0; m_ovf_rr = 0; m_ops_fp = 0; m_ovf_fp = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        #1;
        model_reset();
        chk_both(tag, 16'd0, 16'd0);
        chk_stats(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a falling edge while both DUTs are idle (or in their done cycle).
    task automatic run_op(input string tag, input bit r0, input bit r1,
                          input logic [7:0] x0, input logic [7:0] y0, input bit z0,
                          input logic [7:0] x1, input logic [7:0] y1, input bit z1,
                          input bit scr);
        int w_rr, w_fp, e_rr, e_fp, s0, s1;
        req0 = r0; req1 = r1; a0 = x0; b0 = y0; c0 = z0; a1 = x1; b1 = y1; c1 = z1;
        if (!r0 && !r1) begin
            @(negedge clk);
            chk_both({tag, "_idle"}, pack(2'b00, 1'b0, 1'b0, 1'b0, m_res_rr),
                                     pack(2'b00, 1'b0, 1'b0, 1'b0, m_res_fp));
            return;
        end
        s0   = int'(x0) + int'(y0) + int'(z0);
        s1   = int'(x1) + int'(y1) + int'(z1);
        w_rr = pick(0, r0, r1, last_rr);
        w_fp = pick(1, r0, r1, last_fp);
        e_rr = (w_rr == 0) ? s0 : s1;
        e_fp = (w_fp == 0) ? s0 : s1;
        @(negedge clk);
        chk_both({tag, "_grant"}, pack(gbits(w_rr), 1'b1, 1'b0, 1'b0, m_res_rr),
                                  pack(gbits(w_fp), 1'b1, 1'b0, 1'b0, m_res_fp));
        if (scr) begin
            a0 = x0 + 8'h10; a1 = x1 + 8'h10;
            b0 = 8'($urandom); b1 = 8'($urandom);
            c0 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk_both({tag, "_exec"}, pack(gbits(w_rr), 1'b1, 1'b0, 1'b0, e_rr),
                                 pack(gbits(w_fp), 1'b1, 1'b0, 1'b0, e_fp));
        @(negedge clk);
        m_res_rr = e_rr; m_res_fp = e_fp;
        last_rr = w_rr;  last_fp = w_fp;
        if (m_ops_rr < 255) m_ops_rr++;
        if (m_ops_fp < 255) m_ops_fp++;
        if (e_rr > 255 && m_ovf_rr < 255) m_ovf_rr++;
        if (e_fp > 255 && m_ovf_fp < 255) m_ovf_fp++;
        chk_both({tag, "_done"},
                 pack(2'b00, 1'b0, 1'(w_rr == 1), 1'(w_rr == 0), e_rr),
                 pack(2'b00, 1'b0, 1'(w_fp == 1), 1'(w_fp == 0), e_fp));
        chk_stats({tag, "_done"});
    endtask

    // Start an operation, then reset while it sits in EXEC: no done, outputs zero.
    task automatic abort_op(input string tag);
        req0 = 1'b1; req1 = 1'b0; a0 = 8'h33; b0 = 8'h44; c0 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_both({tag, "_rst"}, 16'd0, 16'd0);
        chk_stats({tag, "_rst"});
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_both({tag, "_after"}, 16'd0, 16'd0);
        end
    endtask

    initial begin
        // Reset held with both requests asserted: nothing may be granted
        @(negedge clk);
        chk_both("reset", 16'd0, 16'd0);
        chk_stats("reset");
        @(negedge clk);
        chk_both("reset_hold", 16'd0, 16'd0);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        run_op("single0", 1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 0, 0);

        do_reset("reset2");
        for (int i = 0; i < 4; i++)
            run_op("tie", 1, 1, 8'h64, 8'h01, 0, 8'h0F, 8'h03, 1, 0);

        run_op("ovf1", 0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h01, 0, 0);
        run_op("ovf0", 1, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 0, 0);
        run_op("idle", 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        run_op("capture", 1, 0, 8'h10, 8'h05, 0, 8'h00, 8'h00, 0, 1);
        run_op("drop1", 0, 1, 8'h00, 8'h00, 0, 8'h80, 8'h7F, 1, 1);
        abort_op("abort");

        for (int i = 0; i < 60; i++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            if (i == 30) do_reset("reset_mid");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter_8bits.md
ADDER_ARBITER_8BITS -- requirements
Module: adder_arbiter_8bits

Interface
REQ-001 Parameter: ARB_MODE, default 0, arbitration policy; 0 = round-robin, 1 = fixed priority (requester 0 wins).
REQ-002 Port: Arb_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: Arb_rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: Arb_req0 / Arb_req1  input  1 each  request from requester 0 / 1; level, held until Done.
REQ-005 Port: Arb_in1_0, Arb_in2_0 / Arb_in1_1, Arb_in2_1  input  8 each  operands of requester 0 / 1.
REQ-006 Port: Arb_cin_0 / Arb_cin_1  input  1 each  carry-in of requester 0 / 1.
REQ-007 Port: Arb_grant  output  2  one-hot owner of the shared adder; 00 when idle.
REQ-008 Port: Arb_done0 / Arb_done1  output  1 each  one-cycle result-valid pulse to requester 0 / 1.
REQ-009 Port: Arb_sum  output  8  registered sum of the last completed operation.
REQ-010 Port: Arb_cout  output  1  registered carry-out of the last completed operation.
REQ-011 Port: Arb_busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL own one shared 8-bit add: {cout,sum} = in1 + in2 + cin; 9-bit result, no other width extension.
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; encoding is implementation-defined.
REQ-014 IDLE: with no request, stay in IDLE with Arb_grant = 00.
REQ-015 IDLE: with one or more requests, pick a winner (REQ-018/019), register its in1/in2/cin into internal operand registers, set Arb_grant one-hot, and go to EXEC.
REQ-016 EXEC: compute the add from the operand registers only, register the result into Arb_sum/Arb_cout, and go to DONE.
REQ-017 DONE: pulse Arb_doneX high for exactly that cycle for the granted requester, update the last-grant pointer, clear Arb_grant, and go to IDLE.
REQ-018 Round-robin (ARB_MODE=0): on a simultaneous request, the requester not granted last SHALL win; with a single request, that requester wins.
REQ-019 Fixed priority (ARB_MODE=1): requester 0 SHALL win whenever Arb_req0 is high.
REQ-020 Latency: a request sampled at IDLE edge E0 SHALL give Arb_doneX high in the cycle after edge E2; throughput is one operation per 3 cycles.
REQ-021 Operands are captured at the grant edge; operand changes after that edge SHALL NOT affect the result.
REQ-022 A request dropped after grant SHALL NOT abort the operation; Done still pulses.
REQ-023 A requester keeping req high in its Done cycle SHALL be re-arbitrated as a new request at the next IDLE edge.
REQ-024 Arb_sum/Arb_cout SHALL hold their value until the next EXEC-to-DONE update.
REQ-025 0xFF + 0x01 + 0 SHALL give sum 0x00, cout 1; 0xFF + 0xFF + 1 SHALL give sum 0xFF, cout 1.

Reset
REQ-026 While Arb_rst is high, the FSM SHALL be IDLE.
REQ-027 While Arb_rst is high, Arb_grant, Arb_done0/1, Arb_sum, Arb_cout, Arb_busy SHALL be 0.
REQ-028 While Arb_rst is high, the last-grant pointer SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-029 Reset in EXEC or DONE SHALL abort the operation immediately with no Done pulse.

Configuration
REQ-030 Macro ADDER_ARB_STATS_EN defined: add output port Arb_ops (8 bits), incremented on every Done pulse, saturating at 0xFF, cleared by reset.
REQ-031 Macro ADDER_ARB_STATS_EN defined: add output port Arb_ovf (8 bits), incremented on Done when cout=1, saturating at 0xFF, cleared by reset.
REQ-032 Macro ADDER_ARB_STATS_EN undefined: Arb_ops and Arb_ovf are absent and all other behaviour is identical.

Verification
REQ-033 Reset, then req0 only with 0x01+0x00+0 -> grant=01, done0 pulse 3 cycles after request edge, sum=0x01, cout=0.
REQ-034 req0 and req1 asserted together, held (0x64+0x01+0 / 0x0F+0x03+1), ARB_MODE=0 -> order 0,1,0,1; sums 0x65 / 0x13 alternate.
REQ-035 Same stimulus as REQ-034 with ARB_MODE=1 -> requester 0 served every round; done1 never pulses.
REQ-036 req1 0xFF+0x01+0 -> sum=0x00, cout=1; with ADDER_ARB_STATS_EN: Arb_ops=1, Arb_ovf=1.
REQ-037 Change in1 from 0x10 to 0x20 in EXEC; assert reset in EXEC on a later op -> result uses 0x10; aborted op gives no done, outputs are 0.
